// File: rtl/wf_retire_tracker.sv
// ---------------------------------------------------------------------------
// wf_retire_tracker
//   Per-wavefront completion tracker for the issue stage. Each wavefront slot
//   keeps an in-flight instruction counter and a halted flag. A slot is
//   offered to fetch as "done" once it has halted, has nothing in flight and
//   is not waiting on memory. Done ids are chosen round-robin and presented
//   through a registered valid/ready output.
//
//   Handshake: o_done_valid/o_done_wfid are loaded only when the output
//   register is empty or is being accepted this cycle
//   (~o_done_valid | i_done_ready). A transfer happens on a cycle where
//   o_done_valid & i_done_ready. While o_done_valid & ~i_done_ready the
//   output holds, whatever happens to i_mem_wait.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-low reset (0 = reset)
//   i_issue_valid/wfid  one instruction issued to wavefront i_issue_wfid
//   i_retire_valid/wfid NUM_RET retire ports, port k id at [k*WF_ID_W +: WF_ID_W]
//   i_halt_valid/wfid   wavefront reached s_endpgm
//   i_alloc_valid/wfid  slot re-dispatched: clears counter and halted flag
//   i_mem_wait          per-wavefront outstanding memory flag
//   o_done_valid/wfid   finished wavefront presented to fetch
//   i_done_ready        fetch accepts o_done_wfid
//   o_max_inflight      per-wavefront counter >= MAX_INFLIGHT (issue stall)
//   o_err               sticky error: counter saturation, bad id, alloc of
//                       the wavefront being presented on done
// ---------------------------------------------------------------------------
module wf_retire_tracker #(
   parameter int NUM_WF       = 40,
   parameter int WF_ID_W      = 6,
   parameter int NUM_RET      = 3,
   parameter int CNT_W        = 4,
   parameter int MAX_INFLIGHT = 15
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_issue_valid,
   input  logic [WF_ID_W-1:0]         i_issue_wfid,
   input  logic [NUM_RET-1:0]         i_retire_valid,
   input  logic [NUM_RET*WF_ID_W-1:0] i_retire_wfid,
   input  logic                       i_halt_valid,
   input  logic [WF_ID_W-1:0]         i_halt_wfid,
   input  logic                       i_alloc_valid,
   input  logic [WF_ID_W-1:0]         i_alloc_wfid,
   input  logic [NUM_WF-1:0]          i_mem_wait,
   output logic                       o_done_valid,
   output logic [WF_ID_W-1:0]         o_done_wfid,
   input  logic                       i_done_ready,
   output logic [NUM_WF-1:0]          o_max_inflight,
   output logic                       o_err
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic [CNT_W-1:0]   r_cnt [NUM_WF];
   logic [CNT_W-1:0]   w_cnt_nxt [NUM_WF];
   logic [NUM_WF-1:0]  r_halted;
   logic [NUM_WF-1:0]  w_halted_nxt;
   logic [NUM_WF-1:0]  w_cand;
   logic               r_done_valid;
   logic [WF_ID_W-1:0] r_done_wfid;
   logic [WF_ID_W-1:0] r_rr;
   logic               r_err;
   logic               w_err_set;
   logic               w_hs;
   logic               w_load;
   logic               w_found;
   logic [WF_ID_W-1:0] w_pick;
   logic [WF_ID_W-1:0] w_scan;
   logic               w_alloc_hit;
   int                 v_sum;
   int                 v_idx;

   assign w_hs   = r_done_valid & i_done_ready;
   assign w_load = ~r_done_valid | i_done_ready;

   // Counter, halted flag, candidate mask and error detection.
   always_comb begin
      w_err_set    = 1'b0;
      w_halted_nxt = r_halted;
      w_cand       = '0;
      w_alloc_hit  = 1'b0;
      v_sum        = 0;

      // Out-of-range ids are dropped (they never match a slot below) but flagged.
      if (i_issue_valid && int'(i_issue_wfid) >= NUM_WF) w_err_set = 1'b1;
      if (i_halt_valid  && int'(i_halt_wfid)  >= NUM_WF) w_err_set = 1'b1;
      if (i_alloc_valid && int'(i_alloc_wfid) >= NUM_WF) w_err_set = 1'b1;
      for (int k = 0; k < NUM_RET; k++) begin
         if (i_retire_valid[k] && int'(i_retire_wfid[k*WF_ID_W +: WF_ID_W]) >= NUM_WF)
            w_err_set = 1'b1;
      end
      // Re-allocating the slot fetch is looking at is a protocol error; the
      // handshake itself is left alone.
      if (i_alloc_valid && r_done_valid && i_alloc_wfid == r_done_wfid) w_err_set = 1'b1;

      for (int i = 0; i < NUM_WF; i++) begin
         w_alloc_hit = i_alloc_valid && (i_alloc_wfid == WF_ID_W'(i));

         v_sum = int'(r_cnt[i]);
         if (i_issue_valid && i_issue_wfid == WF_ID_W'(i)) v_sum = v_sum + 1;
         for (int k = 0; k < NUM_RET; k++) begin
            if (i_retire_valid[k] && i_retire_wfid[k*WF_ID_W +: WF_ID_W] == WF_ID_W'(i))
               v_sum = v_sum - 1;
         end

         if (w_alloc_hit) begin
            w_cnt_nxt[i] = '0;
         end else if (v_sum < 0) begin
            w_cnt_nxt[i] = '0;
            w_err_set    = 1'b1;
         end else if (v_sum > CNT_MAX) begin
            w_cnt_nxt[i] = CNT_W'(CNT_MAX);
            w_err_set    = 1'b1;
         end else begin
            w_cnt_nxt[i] = CNT_W'(v_sum);
         end

         // Priority: accepted done clears, new halt sets, alloc clears last.
         if (w_hs && r_done_wfid == WF_ID_W'(i))               w_halted_nxt[i] = 1'b0;
         if (i_halt_valid && i_halt_wfid == WF_ID_W'(i))      w_halted_nxt[i] = 1'b1;
         if (w_alloc_hit)                                     w_halted_nxt[i] = 1'b0;

         // The slot already on the output is excluded so it is not picked twice.
         w_cand[i] = r_halted[i] && (r_cnt[i] == '0) && !i_mem_wait[i] &&
                     !(r_done_valid && r_done_wfid == WF_ID_W'(i));
      end
   end

   // Round-robin pick: first candidate at or after r_rr, wrapping at NUM_WF.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_scan  = '0;
      v_idx   = 0;
      for (int k = 0; k < NUM_WF; k++) begin
         v_idx = int'(r_rr) + k;
         if (v_idx >= NUM_WF) v_idx = v_idx - NUM_WF;
         w_scan = WF_ID_W'(v_idx);
         if (!w_found && w_cand[w_scan]) begin
            w_found = 1'b1;
            w_pick  = w_scan;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < NUM_WF; i++) r_cnt[i] <= '0;
         r_halted     <= '0;
         r_done_valid <= 1'b0;
         r_done_wfid  <= '0;
         r_rr         <= '0;
         r_err        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_WF; i++) r_cnt[i] <= w_cnt_nxt[i];
         r_halted <= w_halted_nxt;
         if (w_err_set) r_err <= 1'b1;
         if (w_load) begin
            r_done_valid <= w_found;
            if (w_found) begin
               r_done_wfid <= w_pick;
               r_rr        <= (w_pick == WF_ID_W'(NUM_WF - 1)) ? '0 : w_pick + 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_max_inflight = '0;
      for (int i = 0; i < NUM_WF; i++) o_max_inflight[i] = (int'(r_cnt[i]) >= MAX_INFLIGHT);
   end

   assign o_done_valid = r_done_valid;
   assign o_done_wfid  = r_done_wfid;
   assign o_err        = r_err;

endmodule

// File: tb/tb_wf_retire_tracker.sv
module tb_wf_retire_tracker;

   localparam int NUM_WF       = 40;
   localparam int WF_ID_W      = 6;
   localparam int NUM_RET      = 3;
   localparam int CNT_W        = 4;
   localparam int MAX_INFLIGHT = 15;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                       issue_valid;
   logic [WF_ID_W-1:0]         issue_wfid;
   logic [NUM_RET-1:0]         retire_valid;
   logic [NUM_RET*WF_ID_W-1:0] retire_wfid;
   logic                       halt_valid;
   logic [WF_ID_W-1:0]         halt_wfid;
   logic                       alloc_valid;
   logic [WF_ID_W-1:0]         alloc_wfid;
   logic [NUM_WF-1:0]          mem_wait;
   logic                       done_valid;
   logic [WF_ID_W-1:0]         done_wfid;
   logic                       done_ready;
   logic [NUM_WF-1:0]          max_inflight;
   logic                       err;

   wf_retire_tracker #(
      .NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W), .NUM_RET(NUM_RET),
      .CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_issue_valid(issue_valid), .i_issue_wfid(issue_wfid),
      .i_retire_valid(retire_valid), .i_retire_wfid(retire_wfid),
      .i_halt_valid(halt_valid), .i_halt_wfid(halt_wfid),
      .i_alloc_valid(alloc_valid), .i_alloc_wfid(alloc_wfid),
      .i_mem_wait(mem_wait),
      .o_done_valid(done_valid), .o_done_wfid(done_wfid),
      .i_done_ready(done_ready),
      .o_max_inflight(max_inflight), .o_err(err)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [WF_ID_W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_cnt[NUM_WF];
   bit m_halted[NUM_WF];
   bit m_dv, m_err;
   int m_did, m_rr;
   int n_cnt[NUM_WF];
   bit n_halted[NUM_WF];
   bit n_dv, n_err;
   int n_did, n_rr;

   task automatic model_reset();
      for (int i = 0; i < NUM_WF; i++) begin
         m_cnt[i] = 0;
         m_halted[i] = 0;
      end
      m_dv = 0; m_did = 0; m_rr = 0; m_err = 0;
   endtask

   function automatic int ret_id(input int k);
      return int'(retire_wfid[k*WF_ID_W +: WF_ID_W]);
   endfunction

   // Next state from the current model state and the inputs being driven.
   task automatic model_compute();
      bit cand[NUM_WF];
      bit hs;
      int v;
      int j;
      n_err = m_err;
      hs = m_dv && done_ready;
      if (issue_valid && int'(issue_wfid) >= NUM_WF) n_err = 1;
      if (halt_valid && int'(halt_wfid) >= NUM_WF) n_err = 1;
      if (alloc_valid && int'(alloc_wfid) >= NUM_WF) n_err = 1;
      for (int k = 0; k < NUM_RET; k++)
         if (retire_valid[k] && ret_id(k) >= NUM_WF) n_err = 1;
      if (alloc_valid && m_dv && int'(alloc_wfid) == m_did) n_err = 1;
      for (int i = 0; i < NUM_WF; i++) begin
         cand[i] = m_halted[i] && m_cnt[i] == 0 && !mem_wait[i] && !(m_dv && m_did == i);
         v = m_cnt[i];
         if (issue_valid && int'(issue_wfid) == i) v++;
         for (int k = 0; k < NUM_RET; k++)
            if (retire_valid[k] && ret_id(k) == i) v--;
         if (alloc_valid && int'(alloc_wfid) == i) v = 0;
         else if (v < 0) begin v = 0; n_err = 1; end
         else if (v > CNT_MAX) begin v = CNT_MAX; n_err = 1; end
         n_cnt[i] = v;
         n_halted[i] = m_halted[i];
         if (hs && m_did == i) n_halted[i] = 0;
         if (halt_valid && int'(halt_wfid) == i) n_halted[i] = 1;
         if (alloc_valid && int'(alloc_wfid) == i) n_halted[i] = 0;
      end
      n_dv = m_dv; n_did = m_did; n_rr = m_rr;
      if (!m_dv || done_ready) begin
         n_dv = 0;
         for (int k = 0; k < NUM_WF; k++) begin
            j = (m_rr + k) % NUM_WF;
            if (cand[j]) begin
               n_dv = 1; n_did = j; n_rr = (j + 1) % NUM_WF;
               break;
            end
         end
      end
   endtask

   task automatic model_commit();
      for (int i = 0; i < NUM_WF; i++) begin
         m_cnt[i] = n_cnt[i];
         m_halted[i] = n_halted[i];
      end
      m_dv = n_dv; m_did = n_did; m_rr = n_rr; m_err = n_err;
   endtask

   task automatic compare_outputs();
      logic [NUM_WF-1:0] mx;
      for (int i = 0; i < NUM_WF; i++) mx[i] = (m_cnt[i] >= MAX_INFLIGHT);
      chk("done_valid", done_valid, m_dv);
      if (m_dv) chk("done_wfid", done_wfid, m_did);
      chk("max_inflight", max_inflight, mx);
      chk("err", err, m_err);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      issue_valid = 0; retire_valid = '0; halt_valid = 0; alloc_valid = 0;
   endtask

   task automatic step();
      model_compute();
      if (m_dv && done_ready) exp_q.push_back(WF_ID_W'(m_did));
      if (done_valid && done_ready) begin
         if (exp_q.size() == 0) chk("hs_unexpected", 1, 0);
         else chk("hs_id", done_wfid, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      model_commit();
      compare_outputs();
   endtask

   task automatic apply_reset();
      chk("hs_q_drain", exp_q.size(), 0);
      exp_q.delete();
      idle();
      rst = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1;
   endtask

   task automatic issue_n(input int wf, input int n);
      for (int c = 0; c < n; c++) begin
         idle(); issue_valid = 1; issue_wfid = WF_ID_W'(wf);
         step();
      end
      idle();
   endtask

   task automatic halt_one(input int wf);
      idle(); halt_valid = 1; halt_wfid = WF_ID_W'(wf);
      step();
      idle();
   endtask

   task automatic drive_legal();
      int tmp[NUM_WF];
      int wf;
      idle();
      for (int i = 0; i < NUM_WF; i++) tmp[i] = m_cnt[i];
      if ($urandom_range(1, 0) == 1) begin
         wf = $urandom_range(NUM_WF - 1, 0);
         if (m_cnt[wf] < CNT_MAX) begin
            issue_valid = 1; issue_wfid = WF_ID_W'(wf); tmp[wf]++;
         end
      end
      for (int k = 0; k < NUM_RET; k++) begin
         if ($urandom_range(99, 0) < 40) begin
            wf = $urandom_range(NUM_WF - 1, 0);
            if (tmp[wf] > 0) begin
               retire_valid[k] = 1'b1;
               retire_wfid[k*WF_ID_W +: WF_ID_W] = WF_ID_W'(wf);
               tmp[wf]--;
            end
         end
      end
      if ($urandom_range(99, 0) < 15) begin
         halt_valid = 1; halt_wfid = WF_ID_W'($urandom_range(NUM_WF - 1, 0));
      end
      if ($urandom_range(99, 0) < 4) begin
         wf = $urandom_range(NUM_WF - 1, 0);
         if (!(m_dv && m_did == wf)) begin
            alloc_valid = 1; alloc_wfid = WF_ID_W'(wf);
         end
      end
      done_ready = ($urandom_range(99, 0) < 70);
   endtask

   task automatic drive_wild();
      issue_valid  = $urandom_range(1, 0) == 1;
      issue_wfid   = WF_ID_W'($urandom_range(63, 0));
      retire_valid = NUM_RET'($urandom_range(7, 0));
      for (int k = 0; k < NUM_RET; k++)
         retire_wfid[k*WF_ID_W +: WF_ID_W] = WF_ID_W'($urandom_range(63, 0));
      halt_valid   = $urandom_range(3, 0) == 0;
      halt_wfid    = WF_ID_W'($urandom_range(63, 0));
      alloc_valid  = $urandom_range(9, 0) == 0;
      alloc_wfid   = WF_ID_W'($urandom_range(63, 0));
      done_ready   = $urandom_range(1, 0) == 1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1;
      idle();
      issue_wfid = '0; retire_wfid = '0; halt_wfid = '0; alloc_wfid = '0;
      mem_wait = '0; done_ready = 0;
      #2 rst = 0;
      model_reset();
      #1;
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_wfid", done_wfid, 0);
      chk("rst_max_inflight", max_inflight, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst = 1;

      // Three issues, three same-cycle retires, then halt: done two cycles later.
      issue_n(5, 3);
      retire_valid = '1;
      for (int k = 0; k < NUM_RET; k++) retire_wfid[k*WF_ID_W +: WF_ID_W] = WF_ID_W'(5);
      step();
      halt_one(5);
      chk("t1_dv_after_1", done_valid, 0);
      step();
      chk("t1_dv_after_2", done_valid, 1);
      chk("t1_wfid", done_wfid, 5);
      done_ready = 1;
      step();
      chk("t1_drained", done_valid, 0);

      // Round robin with wrap: 1, 2, 39, then 1 again after re-halt.
      done_ready = 0;
      halt_one(1);
      halt_one(2);
      chk("t3_first", done_wfid, 1);
      halt_one(39);
      chk("t3_hold", done_wfid, 1);
      done_ready = 1;
      step();
      chk("t3_second", done_wfid, 2);
      step();
      chk("t3_third", done_wfid, 39);
      step();
      chk("t3_empty", done_valid, 0);
      halt_one(1);
      step();
      chk("t3_rehalt_dv", done_valid, 1);
      chk("t3_rehalt_id", done_wfid, 1);
      step();

      // mem_wait gating, then stability while stalled.
      done_ready = 0;
      mem_wait[3] = 1;
      halt_one(3);
      step(); step();
      chk("t4_gated", done_valid, 0);
      mem_wait[3] = 0;
      step();
      chk("t4_dv", done_valid, 1);
      chk("t4_id", done_wfid, 3);
      mem_wait[3] = 1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("t4_stable_dv", done_valid, 1);
         chk("t4_stable_id", done_wfid, 3);
      end
      mem_wait[3] = 0;
      done_ready = 1;
      step();
      chk("t4_drained", done_valid, 0);

      // Retire underflow, then alloc overriding same-cycle issue and halt.
      idle(); retire_valid[0] = 1; retire_wfid[0 +: WF_ID_W] = WF_ID_W'(9);
      step();
      chk("t5_err", err, 1);
      idle(); alloc_valid = 1; alloc_wfid = WF_ID_W'(9);
      issue_valid = 1; issue_wfid = WF_ID_W'(9);
      halt_valid = 1; halt_wfid = WF_ID_W'(9);
      step();
      idle();
      step(); step();
      chk("t5_alloc_clears_halt", done_valid, 0);
      halt_one(9);
      step();
      chk("t5_cnt_zero_dv", done_valid, 1);
      chk("t5_cnt_zero_id", done_wfid, 9);
      step();

      apply_reset();
      chk("t2_err_cleared", err, 0);

      // Threshold and saturation.
      issue_n(7, 15);
      chk("t2_max_set", max_inflight[7], 1);
      chk("t2_no_err", err, 0);
      idle(); retire_valid[1] = 1; retire_wfid[WF_ID_W +: WF_ID_W] = WF_ID_W'(7);
      step();
      chk("t2_max_clear", max_inflight[7], 0);
      issue_n(7, 1);
      chk("t2_max_again", max_inflight[7], 1);
      chk("t2_no_err2", err, 0);
      issue_n(7, 1);
      chk("t2_sat_err", err, 1);
      chk("t2_sat_max", max_inflight[7], 1);

      // Asynchronous reset in the middle of a stalled handshake.
      done_ready = 0;
      halt_one(4);
      step();
      chk("t6_pre_dv", done_valid, 1);
      #2 rst = 0;
      #1;
      chk("t6_dv", done_valid, 0);
      chk("t6_max", max_inflight, 0);
      chk("t6_err", err, 0);
      model_reset();
      exp_q.delete();
      idle();
      @(negedge clk);
      rst = 1;

      // Legal random traffic: err must stay clear.
      for (int c = 0; c < 1500; c++) begin
         if (c % 4 == 0)
            mem_wait = NUM_WF'({$urandom, $urandom} & {$urandom, $urandom});
         drive_legal();
         step();
      end
      chk("legal_err_clear", err, 0);

      apply_reset();
      // Unconstrained traffic including out-of-range ids.
      for (int c = 0; c < 500; c++) begin
         mem_wait = NUM_WF'({$urandom, $urandom} & {$urandom, $urandom});
         drive_wild();
         step();
      end
      idle();
      done_ready = 1;
      mem_wait = '0;
      for (int c = 0; c < 4; c++) step();
      chk("hs_q_final", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
